// File: rtl/datapath_dispatch4.sv
// Dispatches one command stream across four start/finished datapath units and
// returns their results upstream in issue order through a valid/ready port.
module datapath_dispatch4 #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int RESULT_WIDTH      = 32
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic [INSTRUCTION_WIDTH-1:0]   cmd_instruction,
    input  logic                           cmd_start,
    output logic                           cmd_ready,
    output logic [RESULT_WIDTH-1:0]        rsp_result,
    output logic [1:0]                     rsp_unit,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [INSTRUCTION_WIDTH*4-1:0] instruction_dp,
    output logic [3:0]                     start_dp,
    input  logic [RESULT_WIDTH*4-1:0]      result_dp,
    input  logic [3:0]                     finished_dp
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUED = 2'd1,
        ST_BUSY   = 2'd2,
        ST_DONE   = 2'd3
    } unit_state_t;

    unit_state_t                  state_q [4];
    unit_state_t                  state_d [4];
    logic [RESULT_WIDTH-1:0]      res_q   [4];
    logic [RESULT_WIDTH-1:0]      res_d   [4];
    logic [INSTRUCTION_WIDTH-1:0] instr_q [4];
    logic [INSTRUCTION_WIDTH-1:0] instr_d [4];
    logic [1:0]                   fifo_q  [4];
    logic [1:0]                   fifo_d  [4];
    logic [3:0]                   start_q, start_d;
    logic [1:0]                   head_q, head_d;
    logic [1:0]                   tail_q, tail_d;
    logic [2:0]                   count_q, count_d;

    logic [3:0] selectable;
    logic [1:0] sel_idx;
    logic [1:0] head_unit;
    logic       accept;
    logic       pop;

    // A unit is only offered once its finished level is back high, so a unit
    // still computing across a reset cannot be restarted under its own feet.
    always_comb begin
        selectable = '0;
        for (int i = 0; i < 4; i++) begin
            selectable[i] = (state_q[i] == ST_IDLE) && finished_dp[i];
        end
        sel_idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (selectable[i]) sel_idx = 2'(i);
        end
    end

    assign cmd_ready  = |selectable;
    assign accept     = cmd_start & cmd_ready;
    assign head_unit  = fifo_q[head_q];
    assign rsp_valid  = (count_q != 3'd0) && (state_q[head_unit] == ST_DONE);
    assign pop        = rsp_valid & rsp_ready;
    assign rsp_result = res_q[head_unit];
    assign rsp_unit   = head_unit;
    assign start_dp   = start_q;

    always_comb begin
        instruction_dp = '0;
        for (int i = 0; i < 4; i++) begin
            instruction_dp[i*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH] = instr_q[i];
        end
    end

    always_comb begin
        start_d = '0;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            res_d[i]   = res_q[i];
            instr_d[i] = instr_q[i];
            fifo_d[i]  = fifo_q[i];
        end

        for (int i = 0; i < 4; i++) begin
            case (state_q[i])
                ST_IDLE: begin
                    if (accept && (sel_idx == 2'(i))) begin
                        state_d[i] = ST_ISSUED;
                        instr_d[i] = cmd_instruction;
                        start_d[i] = 1'b1;
                    end
                end
                // finished high here is the stale idle level from before the start
                ST_ISSUED: begin
                    if (!finished_dp[i]) state_d[i] = ST_BUSY;
                end
                ST_BUSY: begin
                    if (finished_dp[i]) begin
                        state_d[i] = ST_DONE;
                        res_d[i]   = result_dp[i*RESULT_WIDTH +: RESULT_WIDTH];
                    end
                end
                ST_DONE: begin
                    if (pop && (head_unit == 2'(i))) state_d[i] = ST_IDLE;
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end

        if (accept) begin
            fifo_d[tail_q] = sel_idx;
            tail_d         = tail_q + 2'd1;
        end
        if (pop) begin
            head_d = head_q + 2'd1;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            start_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_IDLE;
                res_q[i]   <= '0;
                instr_q[i] <= '0;
                fifo_q[i]  <= '0;
            end
        end else begin
            start_q <= start_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                res_q[i]   <= res_d[i];
                instr_q[i] <= instr_d[i];
                fifo_q[i]  <= fifo_d[i];
            end
        end
    end

endmodule

// File: tb/tb_datapath_dispatch4.sv
// Bench for datapath_dispatch4: behavioural unit models plus an in-order
// response scoreboard.
module tb_datapath_dispatch4;

    localparam int IW = 32;
    localparam int RW = 32;

    logic            clock;
    logic            resetn;
    logic [IW-1:0]   cmd_instruction;
    logic            cmd_start;
    logic            cmd_ready;
    logic [RW-1:0]   rsp_result;
    logic [1:0]      rsp_unit;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW*4-1:0] instruction_dp;
    logic [3:0]      start_dp;
    logic [RW*4-1:0] result_dp;
    logic [3:0]      finished_dp;

    datapath_dispatch4 #(.INSTRUCTION_WIDTH(IW), .RESULT_WIDTH(RW)) dut (
        .clock           (clock),
        .resetn          (resetn),
        .cmd_instruction (cmd_instruction),
        .cmd_start       (cmd_start),
        .cmd_ready       (cmd_ready),
        .rsp_result      (rsp_result),
        .rsp_unit        (rsp_unit),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .instruction_dp  (instruction_dp),
        .start_dp        (start_dp),
        .result_dp       (result_dp),
        .finished_dp     (finished_dp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]    unit;
        logic [RW-1:0] result;
    } exp_t;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;
    int            lat      [4];
    int            drop_at  [4];
    int            rise_at  [4];
    logic [RW-1:0] res_cfg  [4];
    logic [IW-1:0] instr_seen [4];
    bit            use_instr = 1'b0;

    task automatic push_exp(input logic [1:0] unit, input logic [RW-1:0] result);
        exp_t e;
        e.unit   = unit;
        e.result = result;
        exp_q.push_back(e);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            drop_at[i] = -1;
            rise_at[i] = -1;
        end
    endtask

    // One clock: score any response handshake in the ending cycle, advance,
    // then let the unit models react to the new start_dp.
    task automatic step();
        exp_t e;
        #1;
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL rsp_unexpected: got unit=%0d result=%h, required no response", rsp_unit, rsp_result);
            end else begin
                e = exp_q.pop_front();
                if (rsp_unit !== e.unit || rsp_result !== e.result)
                    $display("FAIL rsp_order: got unit=%0d result=%h, required unit=%0d result=%h",
                             rsp_unit, rsp_result, e.unit, e.result);
                else
                    n_pass++;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (start_dp[i] === 1'b1) begin
                instr_seen[i] = instruction_dp[i*IW +: IW];
                drop_at[i]    = cyc + 1;
                rise_at[i]    = cyc + 1 + lat[i];
            end
            if (cyc == drop_at[i]) finished_dp[i] = 1'b0;
            if (cyc == rise_at[i]) begin
                finished_dp[i] = 1'b1;
                result_dp[i*RW +: RW] = use_instr ? (instr_seen[i] + 32'h1000) : res_cfg[i];
            end
        end
        #1;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || rsp_valid === 1'b1) && k < budget) begin
            step();
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain_timeout: got %0d responses outstanding, required 0", exp_q.size());
        else
            n_pass++;
        step();
    endtask

    task automatic test_reset();
        resetn          = 1'b0;
        cmd_start       = 1'b0;
        cmd_instruction = '0;
        rsp_ready       = 1'b0;
        finished_dp     = 4'hF;
        result_dp       = '0;
        clear_model();
        step();
        step();
        n_checks++;
        if ({start_dp, rsp_valid, rsp_unit} !== 7'd0)
            $display("FAIL reset_ctrl: got start=%b valid=%b unit=%0d, required 0", start_dp, rsp_valid, rsp_unit);
        else n_pass++;
        n_checks++;
        if (instruction_dp !== '0 || rsp_result !== '0)
            $display("FAIL reset_data: got instr=%h result=%h, required 0", instruction_dp, rsp_result);
        else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_ready_hi: got %b, required 1", cmd_ready);
        else n_pass++;
        finished_dp = 4'h0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL reset_ready_lo: got %b, required 0", cmd_ready);
        else n_pass++;
        finished_dp = 4'hF;
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_single();
        lat[0] = 3;
        res_cfg[0] = 32'h1234;
        rsp_ready = 1'b1;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL single_ready0: got %b, required 1", cmd_ready);
        else n_pass++;
        cmd_instruction = 32'hA5;
        cmd_start = 1'b1;
        push_exp(2'd0, 32'h1234);
        step();                                   // cycle 1
        cmd_start = 1'b0;
        n_checks++;
        if (start_dp !== 4'b0001 || instruction_dp[IW-1:0] !== 32'hA5)
            $display("FAIL single_start: got start=%b instr=%h, required 0001/000000a5", start_dp, instruction_dp[IW-1:0]);
        else n_pass++;
        step();                                   // cycle 2
        n_checks++;
        if (start_dp !== 4'b0000) $display("FAIL single_pulse: got %b, required 0000", start_dp);
        else n_pass++;
        repeat (3) step();                        // cycle 5
        n_checks++;
        if (rsp_valid !== 1'b0) $display("FAIL single_early: got valid=%b, required 0", rsp_valid);
        else n_pass++;
        step();                                   // cycle 6
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'h1234 || rsp_unit !== 2'd0)
            $display("FAIL single_rsp: got valid=%b result=%h unit=%0d, required 1/00001234/0",
                     rsp_valid, rsp_result, rsp_unit);
        else n_pass++;
        step();                                   // cycle 7
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL single_after_pop: got valid=%b ready=%b, required 0/1", rsp_valid, cmd_ready);
        else n_pass++;
        drain(20);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            lat[i] = 20;
            res_cfg[i] = 32'hF0 + 32'(i);
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                cmd_instruction = 32'h10 + 32'(k);
                push_exp(2'(k), 32'hF0 + 32'(k));
            end else begin
                n_checks++;
                if (cmd_ready !== 1'b0) $display("FAIL fill_ready: got %b, required 0", cmd_ready);
                else n_pass++;
                cmd_instruction = 32'hDEAD;
            end
            cmd_start = 1'b1;
            if (k >= 1) begin
                n_checks++;
                if (start_dp !== 4'(1 << (k - 1)))
                    $display("FAIL fill_start%0d: got %b, required %b", k, start_dp, 4'(1 << (k - 1)));
                else n_pass++;
            end
            step();
        end
        cmd_start = 1'b0;
        n_checks++;
        if (start_dp !== 4'b0000) $display("FAIL fill_fifth: got %b, required 0000", start_dp);
        else n_pass++;
        n_checks++;
        if (instruction_dp !== {32'h13, 32'h12, 32'h11, 32'h10})
            $display("FAIL fill_instr: got %h, required 00000013000000120000001100000010", instruction_dp);
        else n_pass++;
        drain(80);
    endtask

    task automatic test_ooo();
        lat[0] = 8;  res_cfg[0] = 32'h11;
        lat[1] = 2;  res_cfg[1] = 32'h22;
        rsp_ready = 1'b1;
        cmd_instruction = 32'h1;
        cmd_start = 1'b1;
        push_exp(2'd0, 32'h11);
        step();
        cmd_instruction = 32'h2;
        push_exp(2'd1, 32'h22);
        n_checks++;
        if (start_dp !== 4'b0001) $display("FAIL ooo_start0: got %b, required 0001", start_dp);
        else n_pass++;
        step();
        cmd_start = 1'b0;
        n_checks++;
        if (start_dp !== 4'b0010) $display("FAIL ooo_start1: got %b, required 0010", start_dp);
        else n_pass++;
        repeat (5) step();                        // cycle 7: unit 1 done, unit 0 busy
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL ooo_wait: got valid=%b ready=%b, required 0/1", rsp_valid, cmd_ready);
        else n_pass++;
        drain(40);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) begin
            lat[i] = 2;
            res_cfg[i] = 32'h5A50 + 32'(i);
        end
        rsp_ready = 1'b0;
        cmd_instruction = 32'h40;
        cmd_start = 1'b1;
        push_exp(2'd0, 32'h5A50);
        step();
        cmd_start = 1'b0;
        repeat (4) step();                        // cycle 5: head unit 0 done
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if ({rsp_valid, rsp_unit, rsp_result} !== {1'b1, 2'd0, 32'h5A50})
                $display("FAIL bp_hold%0d: got valid=%b unit=%0d result=%h, required 1/0/00005a50",
                         k, rsp_valid, rsp_unit, rsp_result);
            else n_pass++;
            n_checks++;
            if (start_dp[0] !== 1'b0) $display("FAIL bp_reselect%0d: got start=%b, required bit0=0", k, start_dp);
            else n_pass++;
            cmd_instruction = 32'h41 + 32'(k);
            cmd_start = 1'b1;
            if (k < 3) push_exp(2'(k + 1), 32'h5A50 + 32'(k + 1));
            if (k >= 3) begin
                n_checks++;
                if (cmd_ready !== 1'b0) $display("FAIL bp_ready%0d: got %b, required 0", k, cmd_ready);
                else n_pass++;
            end
            step();
        end
        cmd_start = 1'b0;                         // cycle 15: release
        rsp_ready = 1'b1;
        step();
        for (int k = 1; k < 4; k++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_unit !== 2'(k))
                $display("FAIL bp_stream%0d: got valid=%b unit=%0d, required 1/%0d", k, rsp_valid, rsp_unit, k);
            else n_pass++;
            step();
        end
        drain(20);
    endtask

    task automatic test_back_to_back_wrap();
        int  issued;
        int  k;
        bit  multi;
        issued = 0;
        k = 0;
        multi = 1'b0;
        use_instr = 1'b1;
        for (int i = 0; i < 4; i++) lat[i] = 3;
        rsp_ready = 1'b1;
        cmd_start = 1'b1;
        while (issued < 12 && k < 200) begin
            cmd_instruction = 32'h100 + 32'(issued);
            if (!$onehot0(start_dp)) multi = 1'b1;
            if (cmd_ready === 1'b1) begin
                push_exp(2'(issued % 4), 32'h1100 + 32'(issued));
                issued++;
            end
            step();
            k++;
        end
        cmd_start = 1'b0;
        n_checks++;
        if (issued != 12) $display("FAIL wrap_issue: got %0d accepts, required 12", issued);
        else n_pass++;
        n_checks++;
        if (multi) $display("FAIL wrap_onehot: got multiple start bits, required at most one");
        else n_pass++;
        drain(60);
        use_instr = 1'b0;
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 4; i++) lat[i] = 20;
        rsp_ready = 1'b0;
        cmd_start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmd_instruction = 32'h60 + 32'(k);
            step();
        end
        cmd_start = 1'b0;
        n_checks++;
        if (start_dp !== 4'b0100) $display("FAIL mid_start: got %b, required 0100", start_dp);
        else n_pass++;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (start_dp !== 4'b0 || instruction_dp !== '0 || rsp_valid !== 1'b0 ||
            rsp_result !== '0 || rsp_unit !== 2'd0)
            $display("FAIL mid_reset: got start=%b instr=%h valid=%b result=%h unit=%0d, required all 0",
                     start_dp, instruction_dp, rsp_valid, rsp_result, rsp_unit);
        else n_pass++;
        clear_model();
        exp_q.delete();
        finished_dp = 4'b1100;                    // units 0/1 still computing
        step();
        resetn = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL mid_ready: got %b, required 1", cmd_ready);
        else n_pass++;
        lat[2] = 2;
        res_cfg[2] = 32'h77;
        cmd_instruction = 32'h77;
        cmd_start = 1'b1;
        push_exp(2'd2, 32'h77);
        rsp_ready = 1'b1;
        step();
        cmd_start = 1'b0;
        n_checks++;
        if (start_dp !== 4'b0100) $display("FAIL mid_skip_busy: got %b, required 0100", start_dp);
        else n_pass++;
        finished_dp[1:0] = 2'b11;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL mid_ready_all: got %b, required 1", cmd_ready);
        else n_pass++;
        drain(20);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            lat[i] = 2;
            res_cfg[i] = '0;
            instr_seen[i] = '0;
        end
        test_reset();
        test_single();
        test_fill();
        test_ooo();
        test_backpressure();
        test_back_to_back_wrap();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
